uart_rx_buffered: RTL and testbench

Parametrised successor to the single-byte UART receiver. It adds a configurable frame width, false-start rejection, framing-error detection and overrun detection. Received words go into a first-word-fall-through FIFO drained with a valid/ready handshake. It sits between the synchronised RsRx pin and consumers such as the display counter or a command parser, so no byte is lost while a consumer is busy.

---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_fifo.sv | 53 +++++
 rtl/uart_rx_buffered.sv | 157 +++++++++++++++
 tb/tb_uart_rx_buffered.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and line/baud constants.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } rx_state_e;

  localparam int   BAUD_115200_AT_10MHZ = 87;
  localparam logic IDLE_LINE            = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; head_o shows the oldest entry, 0 while empty.
module sync_fifo #(
  parameter int WIDTH     = 8,
  parameter int LOG_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic [WIDTH-1:0]     push_data_i,
  input  logic                 pop_i,
  output logic [WIDTH-1:0]     head_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [LOG_DEPTH:0]   count_o
);

  localparam int DEPTH = 2 ** LOG_DEPTH;

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [LOG_DEPTH:0]   count_q;
  logic                 wr_en, rd_en;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (LOG_DEPTH+1)'(DEPTH));
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  assign rd_en = pop_i && !empty_o;
  assign wr_en = push_i && (!full_o || rd_en);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// Buffered UART receiver with false-start, framing and overrun detection.
// Define UART_RX_PARITY_EN to expect an even-parity bit after the data bits.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_CYCLES     = BAUD_115200_AT_10MHZ,
  parameter int DATA_BITS      = 8,
  parameter int FIFO_LOG_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_rx,
  output logic [DATA_BITS-1:0]  data,
  output logic                  valid,
  input  logic                  ready,
  output logic [FIFO_LOG_DEPTH:0] count,
  output logic                  framing_error,
  output logic                  overrun,
  output logic                  parity_error
);

  localparam int CNT_W = $clog2(CLK_CYCLES);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLK_CYCLES - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

  logic                 sync1_q, sync2_q, rx_s;
  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tick, push_req, fe, fifo_full, fifo_empty;
`ifdef UART_RX_PARITY_EN
  logic                 pbad_q, pbad_d, pe;
`endif

  assign rx_s = sync2_q;
  assign tick = (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = tick ? FULL_LOAD : cnt_q - 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    push_req = 1'b0;
    fe       = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbad_d   = pbad_q;
    pe       = 1'b0;
`endif
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_s != IDLE_LINE) begin
          state_d = RX_START;
          cnt_d   = HALF_LOAD;
        end
      end
      RX_START: begin
        bit_d = '0;
        // Line back high at mid start bit means it was a glitch.
        if (tick) state_d = (rx_s == IDLE_LINE) ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (tick) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (tick) begin
          pbad_d  = ^{shift_q, rx_s};
          state_d = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (tick) begin
`ifdef UART_RX_PARITY_EN
          pe       = pbad_q;
          push_req = rx_s && !pbad_q;
`else
          push_req = rx_s;
`endif
          fe      = !rx_s;
          state_d = rx_s ? RX_IDLE : RX_BREAK;
        end
      end
      RX_BREAK: begin
        cnt_d = '0;
        if (rx_s == IDLE_LINE) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= IDLE_LINE;
      sync2_q <= IDLE_LINE;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
`ifdef UART_RX_PARITY_EN
      pbad_q  <= 1'b0;
`endif
    end else begin
      sync1_q <= uart_rx;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
`ifdef UART_RX_PARITY_EN
      pbad_q  <= pbad_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  sync_fifo #(
    .WIDTH     (DATA_BITS),
    .LOG_DEPTH (FIFO_LOG_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_req),
    .push_data_i (shift_q),
    .pop_i       (ready),
    .head_o      (data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (count)
  );

  assign valid         = !fifo_empty;
  // When full the FIFO is non-empty, so ready alone decides whether a slot frees up.
  assign overrun       = push_req && fifo_full && !ready;
  assign framing_error = fe;
`ifdef UART_RX_PARITY_EN
  assign parity_error  = pe;
`else
  assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered: a default-depth instance and a 4-entry instance share one line.
`timescale 1ns/1ps
module tb_uart_rx_buffered;

  localparam int BIT = 87;
`ifdef UART_RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  // Push of a frame happens at the stop-bit sample; ready must be high in the cycle before it.
  localparam int PUSH_OFS = BIT / 2 + 2 + (9 + PBITS) * BIT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic line = 1'b1;
  logic ready_a = 1'b0, ready_b = 1'b0;
  logic [7:0] data_a, data_b;
  logic valid_a, valid_b;
  logic [4:0] count_a;
  logic [2:0] count_b;
  logic fe_a, ovr_a, pe_a, fe_b, ovr_b, pe_b;

  int n_cmp = 0, n_fail = 0;
  int fe_a_n = 0, ovr_a_n = 0, pe_a_n = 0, fe_b_n = 0, ovr_b_n = 0, pe_b_n = 0;

  always #5 clk = ~clk;

  uart_rx_buffered #(.CLK_CYCLES(BIT), .DATA_BITS(8), .FIFO_LOG_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .uart_rx(line), .data(data_a), .valid(valid_a), .ready(ready_a),
    .count(count_a), .framing_error(fe_a), .overrun(ovr_a), .parity_error(pe_a)
  );

  uart_rx_buffered #(.CLK_CYCLES(BIT), .DATA_BITS(8), .FIFO_LOG_DEPTH(2)) dut_b (
    .clk(clk), .rst(rst), .uart_rx(line), .data(data_b), .valid(valid_b), .ready(ready_b),
    .count(count_b), .framing_error(fe_b), .overrun(ovr_b), .parity_error(pe_b)
  );

  always @(negedge clk) begin
    if (fe_a)  fe_a_n++;
    if (ovr_a) ovr_a_n++;
    if (pe_a)  pe_a_n++;
    if (fe_b)  fe_b_n++;
    if (ovr_b) ovr_b_n++;
    if (pe_b)  pe_b_n++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Called on a negedge; the start bit begins immediately. Line is left at the stop value.
  task automatic send_frame(input logic [7:0] v, input logic par, input logic stop_v);
    line = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      line = v[i];
      repeat (BIT) @(negedge clk);
    end
    for (int k = 0; k < PBITS; k++) begin
      line = par;
      repeat (BIT) @(negedge clk);
    end
    line = stop_v;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic gap();
    repeat (2 * BIT) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop_a();
    ready_a = 1'b1;
    @(negedge clk);
    ready_a = 1'b0;
  endtask

  task automatic pop_b();
    ready_b = 1'b1;
    @(negedge clk);
    ready_b = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    line = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid_a: got %b want 0", valid_a); end
    n_cmp++; if (count_a !== 5'd0) begin n_fail++; $display("FAIL reset_count_a: got %0d want 0", count_a); end
    n_cmp++; if (data_a !== 8'h00) begin n_fail++; $display("FAIL reset_data_a: got %h want 00", data_a); end
    n_cmp++; if ({fe_a, ovr_a, pe_a} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses_a: got %b want 000", {fe_a, ovr_a, pe_a}); end
    n_cmp++; if (count_b !== 3'd0) begin n_fail++; $display("FAIL reset_count_b: got %0d want 0", count_b); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid_a: got %b want 0", valid_a); end
  endtask

  task automatic test_two_words();
    do_reset();
    send_frame(8'h55, 1'b0, 1'b1); gap();
    send_frame(8'hA3, 1'b0, 1'b1); gap();
    n_cmp++; if (count_a !== 5'd2) begin n_fail++; $display("FAIL two_words_count: got %0d want 2", count_a); end
    n_cmp++; if (data_a !== 8'h55) begin n_fail++; $display("FAIL two_words_head: got %h want 55", data_a); end
    n_cmp++; if (valid_a !== 1'b1) begin n_fail++; $display("FAIL two_words_valid: got %b want 1", valid_a); end
    pop_a();
    n_cmp++; if (data_a !== 8'hA3) begin n_fail++; $display("FAIL two_words_after_pop_head: got %h want a3", data_a); end
    n_cmp++; if (count_a !== 5'd1) begin n_fail++; $display("FAIL two_words_after_pop_count: got %0d want 1", count_a); end
  endtask

  task automatic test_glitch();
    int fe0, pe0, ovr0;
    fe0 = fe_a_n; pe0 = pe_a_n; ovr0 = ovr_a_n;
    line = 1'b0;
    repeat (12) @(negedge clk);
    line = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    n_cmp++; if (count_a !== 5'd1) begin n_fail++; $display("FAIL glitch_count: got %0d want 1", count_a); end
    n_cmp++; if ((fe_a_n - fe0) + (pe_a_n - pe0) + (ovr_a_n - ovr0) !== 0) begin n_fail++; $display("FAIL glitch_pulses: got %0d want 0", (fe_a_n - fe0) + (pe_a_n - pe0) + (ovr_a_n - ovr0)); end
    send_frame(8'h5A, 1'b0, 1'b1); gap();
    n_cmp++; if (count_a !== 5'd2) begin n_fail++; $display("FAIL glitch_next_count: got %0d want 2", count_a); end
    pop_a();
    n_cmp++; if (data_a !== 8'h5A) begin n_fail++; $display("FAIL glitch_next_data: got %h want 5a", data_a); end
    pop_a();
    n_cmp++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL glitch_empty_valid: got %b want 0", valid_a); end
    n_cmp++; if (data_a !== 8'h00) begin n_fail++; $display("FAIL glitch_empty_data: got %h want 00", data_a); end
    pop_a();
    n_cmp++; if (count_a !== 5'd0) begin n_fail++; $display("FAIL ready_when_empty_count: got %0d want 0", count_a); end
  endtask

  task automatic test_framing();
    int fe0;
    do_reset();
    fe0 = fe_a_n;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (20 * BIT) @(negedge clk);
    line = 1'b1;
    gap();
    n_cmp++; if (fe_a_n - fe0 !== 1) begin n_fail++; $display("FAIL framing_pulses: got %0d want 1", fe_a_n - fe0); end
    n_cmp++; if (count_a !== 5'd0) begin n_fail++; $display("FAIL framing_count: got %0d want 0", count_a); end
    send_frame(8'h81, 1'b0, 1'b1); gap();
    n_cmp++; if (data_a !== 8'h81) begin n_fail++; $display("FAIL framing_recover_data: got %h want 81", data_a); end
    n_cmp++; if (count_a !== 5'd1) begin n_fail++; $display("FAIL framing_recover_count: got %0d want 1", count_a); end
    n_cmp++; if (fe_a_n - fe0 !== 1) begin n_fail++; $display("FAIL framing_recover_pulses: got %0d want 1", fe_a_n - fe0); end
  endtask

  task automatic test_overrun();
    int ovr0, ovra0;
    do_reset();
    ovr0 = ovr_b_n; ovra0 = ovr_a_n;
    for (int v = 1; v <= 5; v++) begin
      send_frame(8'(v), ^8'(v), 1'b1);
      gap();
    end
    n_cmp++; if (count_b !== 3'd4) begin n_fail++; $display("FAIL overrun_count: got %0d want 4", count_b); end
    n_cmp++; if (ovr_b_n - ovr0 !== 1) begin n_fail++; $display("FAIL overrun_pulses: got %0d want 1", ovr_b_n - ovr0); end
    n_cmp++; if (ovr_a_n - ovra0 !== 0) begin n_fail++; $display("FAIL overrun_deep_fifo: got %0d want 0", ovr_a_n - ovra0); end
    n_cmp++; if (count_a !== 5'd5) begin n_fail++; $display("FAIL overrun_deep_count: got %0d want 5", count_a); end
    for (int i = 1; i <= 4; i++) begin
      n_cmp++; if (data_b !== 8'(i)) begin n_fail++; $display("FAIL overrun_drain_%0d: got %h want %h", i, data_b, 8'(i)); end
      pop_b();
    end
    n_cmp++; if (valid_b !== 1'b0) begin n_fail++; $display("FAIL overrun_drained_valid: got %b want 0", valid_b); end
  endtask

  task automatic test_full_pop();
    int ovr0;
    do_reset();
    for (int v = 1; v <= 4; v++) begin
      send_frame(8'(v), ^8'(v), 1'b1);
      gap();
    end
    n_cmp++; if (count_b !== 3'd4) begin n_fail++; $display("FAIL full_pop_prefill: got %0d want 4", count_b); end
    ovr0 = ovr_b_n;
    fork
      send_frame(8'h05, 1'b0, 1'b1);
      begin
        repeat (PUSH_OFS) @(posedge clk);
        @(negedge clk);
        ready_b = 1'b1;
        @(negedge clk);
        ready_b = 1'b0;
      end
    join
    gap();
    n_cmp++; if (ovr_b_n - ovr0 !== 0) begin n_fail++; $display("FAIL full_pop_overrun: got %0d want 0", ovr_b_n - ovr0); end
    n_cmp++; if (count_b !== 3'd4) begin n_fail++; $display("FAIL full_pop_count: got %0d want 4", count_b); end
    for (int i = 2; i <= 5; i++) begin
      n_cmp++; if (data_b !== 8'(i)) begin n_fail++; $display("FAIL full_pop_drain_%0d: got %h want %h", i, data_b, 8'(i)); end
      pop_b();
    end
  endtask

  task automatic test_parity();
`ifdef UART_RX_PARITY_EN
    int pe0, fe0;
    do_reset();
    pe0 = pe_a_n; fe0 = fe_a_n;
    send_frame(8'h07, 1'b1, 1'b1); gap();
    n_cmp++; if (count_a !== 5'd1) begin n_fail++; $display("FAIL parity_good_count: got %0d want 1", count_a); end
    n_cmp++; if (data_a !== 8'h07) begin n_fail++; $display("FAIL parity_good_data: got %h want 07", data_a); end
    n_cmp++; if (pe_a_n - pe0 !== 0) begin n_fail++; $display("FAIL parity_good_pulses: got %0d want 0", pe_a_n - pe0); end
    send_frame(8'h07, 1'b0, 1'b1); gap();
    n_cmp++; if (pe_a_n - pe0 !== 1) begin n_fail++; $display("FAIL parity_bad_pulses: got %0d want 1", pe_a_n - pe0); end
    n_cmp++; if (count_a !== 5'd1) begin n_fail++; $display("FAIL parity_bad_count: got %0d want 1", count_a); end
    n_cmp++; if (fe_a_n - fe0 !== 0) begin n_fail++; $display("FAIL parity_bad_framing: got %0d want 0", fe_a_n - fe0); end
`else
    n_cmp++; if (pe_a_n + pe_b_n !== 0) begin n_fail++; $display("FAIL parity_off_pulses: got %0d want 0", pe_a_n + pe_b_n); end
`endif
  endtask

  task automatic test_mid_reset();
    int fe0;
    do_reset();
    send_frame(8'h11, 1'b0, 1'b1); gap();
    n_cmp++; if (count_a !== 5'd1) begin n_fail++; $display("FAIL mid_reset_prefill: got %0d want 1", count_a); end
    fe0 = fe_a_n;
    fork
      send_frame(8'hF8, 1'b1, 1'b1);
      begin
        repeat (6 * BIT + 40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (count_a !== 5'd0) begin n_fail++; $display("FAIL mid_reset_count: got %0d want 0", count_a); end
        n_cmp++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b want 0", valid_a); end
      end
    join
    gap();
    n_cmp++; if (count_a !== 5'd0) begin n_fail++; $display("FAIL mid_reset_no_push: got %0d want 0", count_a); end
    n_cmp++; if (fe_a_n - fe0 !== 0) begin n_fail++; $display("FAIL mid_reset_framing: got %0d want 0", fe_a_n - fe0); end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_glitch();
    test_framing();
    test_overrun();
    test_full_pop();
    test_parity();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
